exhaustive_vector_sweeper: RTL and testbench

- Parametrised, self-checking exhaustive stimulus engine for N-input combinational blocks.
- On start, it drives every input combination onto the DUT inputs in binary or Gray order and holds each vector for a programmable number of clocks.
- It samples the DUT's 1-bit output at the end of each hold window and compares it against a truth-table parameter.
- It reports the mismatch count, the first failing vector and pass/fail. It replaces hand-written per-vector delay stimulus in our gate-level benches and is synthesizable for on-board self-test.

---
 rtl/exhaustive_vector_sweeper.sv | 155 +++++++++++++++
 tb/tb_exhaustive_vector_sweeper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_sweeper.sv
// Exhaustive stimulus engine: walks all 2^N_IN input vectors (binary or Gray order),
// holds each for HOLD_CYCLES clocks and checks the DUT's 1-bit response against EXPECT_MASK.
module exhaustive_vector_sweeper #(
    parameter int                     N_IN        = 3,
    parameter int                     HOLD_CYCLES = 20,
    parameter logic [(1<<N_IN)-1:0]   EXPECT_MASK = 8'b1110_1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            gray_mode,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            fail_seen
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            mode_q, mode_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   mismatch_count_q, mismatch_count_d;
    logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;
    logic            fail_seen_q, fail_seen_d;

    logic [N_IN-1:0] idx_inc;
    logic            launch;

    assign idx_inc = idx_q + N_IN'(1);
    assign launch  = start && !abort;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        hold_cnt_d       = hold_cnt_q;
        mode_d           = mode_q;
        vec_d            = vec_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        mismatch_count_d = mismatch_count_q;
        first_fail_vec_d = first_fail_vec_q;
        fail_seen_d      = fail_seen_q;

        case (state_q)
            S_DRIVE: begin
                if (abort) begin
                    // Statistics are deliberately left intact so an aborted run can be inspected.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                    if (hold_cnt_q == HOLD_LAST) begin
                        if (dut_out != EXPECT_MASK[vec_q]) begin
                            mismatch_count_d = mismatch_count_q + (N_IN+1)'(1);
                            if (!fail_seen_q) begin
                                first_fail_vec_d = vec_q;
                                fail_seen_d      = 1'b1;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (mismatch_count_d == '0);
                        end else begin
                            idx_d      = idx_inc;
                            hold_cnt_d = '0;
                            vec_d      = mode_q ? (idx_inc ^ (idx_inc >> 1)) : idx_inc;
                        end
                    end
                end
            end
            default: begin
                if (state_q == S_DONE && abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                end else if (launch) begin
                    // Vector 0 is the same in both orders, so it can be driven immediately.
                    state_d          = S_DRIVE;
                    idx_d            = '0;
                    hold_cnt_d       = '0;
                    mode_d           = gray_mode;
                    vec_d            = '0;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    mismatch_count_d = '0;
                    first_fail_vec_d = '0;
                    fail_seen_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            hold_cnt_q       <= '0;
            mode_q           <= 1'b0;
            vec_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            mismatch_count_q <= '0;
            first_fail_vec_q <= '0;
            fail_seen_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            hold_cnt_q       <= hold_cnt_d;
            mode_q           <= mode_d;
            vec_q            <= vec_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            mismatch_count_q <= mismatch_count_d;
            first_fail_vec_q <= first_fail_vec_d;
            fail_seen_q      <= fail_seen_d;
        end
    end

    assign vec            = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_count = mismatch_count_q;
    assign first_fail_vec = first_fail_vec_q;
    assign fail_seen      = fail_seen_q;

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// Bench for exhaustive_vector_sweeper: a 3-input/hold-4 instance driven through a sweep table
// and corner sequences, plus a 2-input/hold-1 XOR instance.
module tb_exhaustive_vector_sweeper;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: N_IN=3, HOLD_CYCLES=4, majority mask
    logic       start, abort, gray_mode, dut_out;
    logic [2:0] vec, first_fail_vec;
    logic [3:0] mismatch_count;
    logic       busy, done, pass, fail_seen;
    int         fault_sel;   // 0 = majority, 1 = stuck-at-0, 2 = stuck-at-1

    always_comb begin
        case (fault_sel)
            1:       dut_out = 1'b0;
            2:       dut_out = 1'b1;
            default: dut_out = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
        endcase
    end

    exhaustive_vector_sweeper #(.N_IN(3), .HOLD_CYCLES(4), .EXPECT_MASK(8'b1110_1000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gray_mode(gray_mode),
        .dut_out(dut_out), .vec(vec), .busy(busy), .done(done), .pass(pass),
        .mismatch_count(mismatch_count), .first_fail_vec(first_fail_vec), .fail_seen(fail_seen)
    );

    // Instance B: N_IN=2, HOLD_CYCLES=1, XOR mask
    logic       start2, dut_out2;
    logic [1:0] vec2, first_fail_vec2;
    logic [2:0] mismatch_count2;
    logic       busy2, done2, pass2, fail_seen2;
    assign dut_out2 = vec2[1] ^ vec2[0];

    exhaustive_vector_sweeper #(.N_IN(2), .HOLD_CYCLES(1), .EXPECT_MASK(4'b0110)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .gray_mode(1'b0),
        .dut_out(dut_out2), .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_count(mismatch_count2), .first_fail_vec(first_fail_vec2), .fail_seen(fail_seen2)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic gray;
        int   fault;
        int   exp_mm;
        int   exp_first;
        logic exp_fail;
        logic exp_pass;
    } sweep_rec_t;
    sweep_rec_t tbl[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one full sweep on instance A; expected vectors go into the scoreboard at start.
    task automatic run_sweep(input logic g, input int f, input logic poke);
        @(negedge clk);
        fault_sel = f;
        gray_mode = g;
        start     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int kv;
            kv = g ? (k ^ (k >> 1)) : k;
            exp_q.push_back(kv[2:0]);
        end
        wait_edges(1);
        start = 1'b0;
        check("t0_busy", busy, 1);
        check("t0_done", done, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("vec%0d", k), vec, exp_q.pop_front());
            if (poke && k == 3) begin
                @(negedge clk);
                start = 1'b1;
                wait_edges(1);
                start = 1'b0;
                wait_edges(3);
            end else if (k == 7) begin
                wait_edges(3);
                check("busy_before_end", busy, 1);
                check("done_before_end", done, 0);
                wait_edges(1);
            end else begin
                wait_edges(4);
            end
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        $display("sweep gray=%0d fault=%0d poke=%0d -> mm=%0d first=%0d fail_seen=%0d pass=%0d",
                 g, f, poke, mismatch_count, first_fail_vec, fail_seen, pass);
    endtask

    task automatic check_stats(input string tag, input int mm, input int first, input logic fs, input logic ps);
        check({tag, "_mm"}, mismatch_count, mm);
        check({tag, "_first"}, first_fail_vec, first);
        check({tag, "_fail_seen"}, fail_seen, fs);
        check({tag, "_pass"}, pass, ps);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{gray: 1'b0, fault: 0, exp_mm: 0, exp_first: 0, exp_fail: 1'b0, exp_pass: 1'b1};
        tbl[1] = '{gray: 1'b0, fault: 1, exp_mm: 4, exp_first: 3, exp_fail: 1'b1, exp_pass: 1'b0};
        tbl[2] = '{gray: 1'b1, fault: 0, exp_mm: 0, exp_first: 0, exp_fail: 1'b0, exp_pass: 1'b1};
        tbl[3] = '{gray: 1'b1, fault: 2, exp_mm: 4, exp_first: 0, exp_fail: 1'b1, exp_pass: 1'b0};
        tbl[4] = '{gray: 1'b0, fault: 2, exp_mm: 4, exp_first: 0, exp_fail: 1'b1, exp_pass: 1'b0};

        start = 0; abort = 0; gray_mode = 0; fault_sel = 0; start2 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_vec", vec, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_stats("rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_sweep(tbl[i].gray, tbl[i].fault, 1'b0);
            check_stats($sformatf("tbl%0d", i), tbl[i].exp_mm, tbl[i].exp_first, tbl[i].exp_fail, tbl[i].exp_pass);
        end

        // Abort during vector 5: stats from the partial run are retained
        @(negedge clk);
        fault_sel = 1; gray_mode = 0; start = 1'b1;
        wait_edges(1);
        start = 1'b0;
        wait_edges(21);
        check("abort_pre_vec", vec, 5);
        check("abort_pre_mm", mismatch_count, 1);
        @(negedge clk);
        abort = 1'b1;
        wait_edges(1);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_vec", vec, 0);
        check_stats("abort", 1, 3, 1, 0);
        $display("abort sequence: vec=%0d busy=%0d done=%0d mm=%0d", vec, busy, done, mismatch_count);
        run_sweep(1'b0, 0, 1'b0);
        check_stats("after_abort", 0, 0, 0, 1);

        // Mid-sweep start pulse must not restart or shift completion
        run_sweep(1'b0, 1, 1'b1);
        check_stats("poke", 4, 3, 1, 0);

        // Asynchronous reset between edges mid-sweep
        @(negedge clk);
        fault_sel = 1; gray_mode = 0; start = 1'b1;
        wait_edges(1);
        start = 1'b0;
        wait_edges(18);
        check("prereset_mm", mismatch_count, 1);
        #3 rst_n = 1'b0;
        #1;
        check("areset_vec", vec, 0);
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check_stats("areset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(3);
        check("idle_busy", busy, 0);
        check("idle_vec", vec, 0);
        $display("async reset sequence: vec=%0d busy=%0d mm=%0d", vec, busy, mismatch_count);
        run_sweep(1'b1, 0, 1'b0);
        check_stats("after_reset", 0, 0, 0, 1);

        // HOLD_CYCLES=1, N_IN=2 XOR instance
        @(negedge clk);
        start2 = 1'b1;
        wait_edges(1);
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] kv;
            kv = k;
            check($sformatf("h1_vec%0d", k), vec2, kv);
            check($sformatf("h1_busy%0d", k), busy2, 1);
            check($sformatf("h1_done%0d", k), done2, 0);
            wait_edges(1);
        end
        check("h1_done", done2, 1);
        check("h1_busy_end", busy2, 0);
        check("h1_pass", pass2, 1);
        check("h1_mm", mismatch_count2, 0);
        check("h1_fail_seen", fail_seen2, 0);
        check("h1_vec_hold", vec2, 3);
        $display("hold1 sweep: done=%0d pass=%0d mm=%0d", done2, pass2, mismatch_count2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
